// File: rtl/register_file_sb_pkg.sv
// Shared types and helpers for register_file_sb.
// wport_select gives the highest-index hit.
package regfile_pkg;

  localparam int N_DEF     = 5;
  localparam int WIDTH_DEF = 32;
  localparam int MAX_PORTS = 8;

  typedef logic [N_DEF-1:0]     reg_addr_t;
  typedef logic [WIDTH_DEF-1:0] reg_data_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } wsel_t;

  function automatic wsel_t wport_select(
    input logic [MAX_PORTS-1:0] match
  );
    wsel_t s;
    s = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (match[k]) begin
        s.hit = 1'b1;
        s.idx = 3'(k);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of register_file_sb.
// master drives writes, issue and reads.
interface register_file_sb_if #(
  parameter int N      = 5,
  parameter int WIDTH  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);

  logic [NWRITE-1:0]       wenable;
  logic [NWRITE*N-1:0]     reg_in;
  logic [NWRITE*WIDTH-1:0] din;
  logic [NWRITE-1:0]       wclear;
  logic                    issue;
  logic [N-1:0]            issue_rd;
  logic [NREAD*N-1:0]      raddr;
  logic [NREAD*WIDTH-1:0]  rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    busy_any;

  modport master (
    output wenable, reg_in, din, wclear,
    output issue, issue_rd, raddr,
    input  rdata, rbusy, busy_any
  );

  modport slave (
    input  wenable, reg_in, din, wclear,
    input  issue, issue_rd, raddr,
    output rdata, rbusy, busy_any
  );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy bits; a new issue beats
// a same-cycle clear of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N        = 5,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWRITE-1:0]   wenable,
  input  logic [NWRITE-1:0]   wclear,
  input  logic [NWRITE*N-1:0] reg_in,
  input  logic                issue,
  input  logic [N-1:0]        issue_rd,
  input  logic [NREAD*N-1:0]  raddr,
  input  logic [NREAD-1:0]    byp_clr,
  output logic [NREAD-1:0]    rbusy,
  output logic                busy_any
);

  localparam int DEPTH = 2**N;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             clr;
  logic             set;
  logic [N-1:0]     ra;

  // next busy vector: set has priority over clear
  always_comb begin
    busy_nxt = busy;
    clr      = 1'b0;
    set      = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      clr = 1'b0;
      for (int k = 0; k < NWRITE; k++) begin
        clr = clr | (wenable[k] && wclear[k] &&
              (reg_in[k*N +: N] == N'(r)));
      end
      set = issue && (issue_rd == N'(r)) &&
            !(ZERO_REG != 0 && r == 0);
      busy_nxt[r] = set | (busy[r] & ~clr);
    end
  end

  // busy register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // per-port busy lookup
  always_comb begin
    rbusy = '0;
    ra    = '0;
    for (int j = 0; j < NREAD; j++) begin
      ra       = raddr[j*N +: N];
      rbusy[j] = busy[ra] && !byp_clr[j] &&
                 !(ZERO_REG != 0 && ra == '0);
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with scoreboard.
// Macro REGFILE_BYPASS_EN: same-cycle forwarding.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int N        = 5,
  parameter int WIDTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_sb_if.slave bus
);

  localparam int DEPTH = 2**N;

  logic [WIDTH-1:0]     regs [DEPTH];
  logic [WIDTH-1:0]     wval [DEPTH];
  logic [DEPTH-1:0]     wdo;
  logic [MAX_PORTS-1:0] wm;
  wsel_t                ws;
  logic [NREAD-1:0]     byp_clr;
  logic [N-1:0]         ra;
  logic [WIDTH-1:0]     rd;
`ifdef REGFILE_BYPASS_EN
  logic [MAX_PORTS-1:0] rm;
  wsel_t                rs;
`endif

  // per-register write decode, highest port wins
  always_comb begin
    wm  = '0;
    ws  = '0;
    wdo = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wval[r] = '0;
    end
    for (int r = 0; r < DEPTH; r++) begin
      wm = '0;
      for (int k = 0; k < NWRITE; k++) begin
        wm[k] = bus.wenable[k] &&
                (bus.reg_in[k*N +: N] == N'(r));
      end
      ws     = wport_select(wm);
      wdo[r] = ws.hit && !(ZERO_REG != 0 && r == 0);
      for (int k = 0; k < NWRITE; k++) begin
        if (int'(ws.idx) == k) begin
          wval[r] = bus.din[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // storage array with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wdo[r]) begin
          regs[r] <= wval[r];
        end
      end
    end
  end

  // combinational read muxes
  always_comb begin
    bus.rdata = '0;
    byp_clr   = '0;
    ra        = '0;
    rd        = '0;
`ifdef REGFILE_BYPASS_EN
    rm = '0;
    rs = '0;
`endif
    for (int j = 0; j < NREAD; j++) begin
      ra = bus.raddr[j*N +: N];
      rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
      rm = '0;
      for (int k = 0; k < NWRITE; k++) begin
        rm[k] = bus.wenable[k] &&
                (bus.reg_in[k*N +: N] == ra);
      end
      rs = wport_select(rm);
      for (int k = 0; k < NWRITE; k++) begin
        if (rs.hit && int'(rs.idx) == k) begin
          rd         = bus.din[k*WIDTH +: WIDTH];
          byp_clr[j] = bus.wclear[k];
        end
      end
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        rd = '0;
      end
      bus.rdata[j*WIDTH +: WIDTH] = rd;
    end
  end

  regfile_scoreboard #(
    .N        (N),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wenable  (bus.wenable),
    .wclear   (bus.wclear),
    .reg_in   (bus.reg_in),
    .issue    (bus.issue),
    .issue_rd (bus.issue_rd),
    .raddr    (bus.raddr),
    .byp_clr  (byp_clr),
    .rbusy    (bus.rbusy),
    .busy_any (bus.busy_any)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb.
// Reference model is a plain array plus busy flags.
module tb_register_file_sb;
  import regfile_pkg::*;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  register_file_sb_if #(
    .N(N), .WIDTH(W), .NREAD(NR), .NWRITE(NW)
  ) bus ();

  register_file_sb #(
    .N(N), .WIDTH(W), .NREAD(NR),
    .NWRITE(NW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic                  chk;
    logic [NR-1:0][W-1:0]  d;
    logic [NR-1:0]         b;
    logic                  any;
  } exp_t;

  exp_t q[$];
  exp_t me;

  int checks = 0;
  int errors = 0;

  reg_data_t mem [32];
  logic      bsy [32];
  logic      started = 1'b0;

  logic      t_wen [NW];
  reg_addr_t t_wa  [NW];
  reg_data_t t_wd  [NW];
  logic      t_wc  [NW];
  logic      t_iss;
  reg_addr_t t_ird;
  reg_addr_t t_ra  [NR];
  logic      t_rst;

  function automatic reg_addr_t pick();
    if ($urandom_range(0, 1) == 1)
      return reg_addr_t'($urandom_range(0, 7));
    return reg_addr_t'($urandom_range(0, 31));
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < NW; k++) begin
      t_wen[k] = 1'b0;
      t_wa[k]  = '0;
      t_wd[k]  = '0;
      t_wc[k]  = 1'b0;
    end
    t_iss = 1'b0;
    t_ird = '0;
    t_rst = 1'b0;
    for (int j = 0; j < NR; j++) t_ra[j] = '0;
  endtask

  // drive one cycle, predict outputs, advance model
  task automatic step();
    exp_t e;
    int   hk;
    reg_addr_t a;
    rst = t_rst;
    for (int k = 0; k < NW; k++) begin
      bus.wenable[k]        = t_wen[k];
      bus.reg_in[k*N +: N]  = t_wa[k];
      bus.din[k*W +: W]     = t_wd[k];
      bus.wclear[k]         = t_wc[k];
    end
    bus.issue    = t_iss;
    bus.issue_rd = t_ird;
    for (int j = 0; j < NR; j++)
      bus.raddr[j*N +: N] = t_ra[j];

    e     = '0;
    e.chk = started && !t_rst;
    for (int j = 0; j < NR; j++) begin
      a      = t_ra[j];
      e.d[j] = mem[a];
      e.b[j] = bsy[a];
`ifdef REGFILE_BYPASS_EN
      hk = -1;
      for (int k = 0; k < NW; k++)
        if (t_wen[k] && t_wa[k] == a) hk = k;
      if (hk >= 0) begin
        e.d[j] = t_wd[hk];
        if (t_wc[hk]) e.b[j] = 1'b0;
      end
`else
      hk = 0;
`endif
      if (a == 0) begin
        e.d[j] = '0;
        e.b[j] = 1'b0;
      end
    end
    for (int r = 0; r < 32; r++) e.any = e.any | bsy[r];
    q.push_back(e);

    @(posedge clk);
    if (t_rst) begin
      for (int r = 0; r < 32; r++) begin
        mem[r] = '0;
        bsy[r] = 1'b0;
      end
      started = 1'b1;
    end else begin
      for (int k = 0; k < NW; k++)
        if (t_wen[k] && t_wa[k] != 0) mem[t_wa[k]] = t_wd[k];
      for (int k = 0; k < NW; k++)
        if (t_wen[k] && t_wc[k]) bsy[t_wa[k]] = 1'b0;
      if (t_iss && t_ird != 0) bsy[t_ird] = 1'b1;
    end
    #1;
  endtask

  task automatic wr(input int k, input int a,
                    input logic [W-1:0] d, input logic c);
    t_wen[k] = 1'b1;
    t_wa[k]  = reg_addr_t'(a);
    t_wd[k]  = d;
    t_wc[k]  = c;
  endtask

  task automatic rd2(input int a0, input int a1);
    t_ra[0] = reg_addr_t'(a0);
    t_ra[1] = reg_addr_t'(a1);
  endtask

  // monitor: compare presented outputs with queue head
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      if (me.chk) begin
        for (int j = 0; j < NR; j++) begin
          checks++;
          if (bus.rdata[j*W +: W] !== me.d[j]) begin
            errors++;
            $display("FAIL rdata%0d addr %0d: got %h want %h",
                     j, bus.raddr[j*N +: N],
                     bus.rdata[j*W +: W], me.d[j]);
          end
          checks++;
          if (bus.rbusy[j] !== me.b[j]) begin
            errors++;
            $display("FAIL rbusy%0d addr %0d: got %b want %b",
                     j, bus.raddr[j*N +: N],
                     bus.rbusy[j], me.b[j]);
          end
        end
        checks++;
        if (bus.busy_any !== me.any) begin
          errors++;
          $display("FAIL busy_any: got %b want %b",
                   bus.busy_any, me.any);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      mem[r] = '0;
      bsy[r] = 1'b0;
    end
    clear_stim();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset, then sweep every address
    t_rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      clear_stim();
      rd2(2*i, 2*i + 1);
      step();
    end

    // basic write and zero-register write
    clear_stim();
    wr(0, 5, 32'hDEADBEEF, 1'b0);
    wr(1, 0, 32'h0000_1234, 1'b0);
    step();
    clear_stim();
    rd2(5, 0);
    step();

    // same-address conflict
    clear_stim();
    wr(0, 7, 32'h11, 1'b0);
    wr(1, 7, 32'h22, 1'b0);
    step();
    clear_stim();
    rd2(7, 5);
    step();

    // issue, then writeback with clear
    clear_stim();
    t_iss = 1'b1;
    t_ird = 5'd3;
    step();
    clear_stim();
    rd2(3, 0);
    step();
    clear_stim();
    wr(0, 3, 32'h3333, 1'b1);
    rd2(3, 3);
    step();
    clear_stim();
    rd2(3, 0);
    step();

    // issue and clear of the same register
    clear_stim();
    t_iss = 1'b1;
    t_ird = 5'd9;
    step();
    clear_stim();
    t_iss = 1'b1;
    t_ird = 5'd9;
    wr(1, 9, 32'h9999, 1'b1);
    rd2(9, 9);
    step();
    clear_stim();
    rd2(9, 3);
    step();

    // write with clear while reading same register
    clear_stim();
    t_iss = 1'b1;
    t_ird = 5'd4;
    step();
    clear_stim();
    wr(1, 4, 32'h0000_A5A5, 1'b1);
    rd2(4, 4);
    step();
    clear_stim();
    rd2(4, 4);
    step();

    // reset mid-operation
    clear_stim();
    wr(0, 2, 32'hFF, 1'b0);
    t_iss = 1'b1;
    t_ird = 5'd2;
    t_rst = 1'b1;
    rd2(2, 9);
    step();
    clear_stim();
    rd2(2, 9);
    step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      clear_stim();
      t_rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < NW; k++) begin
        t_wen[k] = 1'($urandom_range(0, 1));
        t_wa[k]  = pick();
        t_wd[k]  = $urandom;
        t_wc[k]  = t_wen[k] & 1'($urandom_range(0, 1));
      end
      t_iss = ($urandom_range(0, 2) == 0);
      t_ird = pick();
      for (int j = 0; j < NR; j++) t_ra[j] = pick();
      step();
    end

    clear_stim();
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
